// File: rtl/alu_defs_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs_pkg
// Shared definitions for the ALU and everything that feeds it:
//   - opcode / funct encodings understood by ALU
//   - requester IDs used by the shared-ALU arbiter
//   - alu_ctl_t: the width-independent control fields of one ALU operation
// ---------------------------------------------------------------------------
package alu_defs_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type funct fields
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLTU = 6'b101011;

  // Requester IDs
  localparam logic REQ_EXEC = 1'b0;  // execute stage
  localparam logic REQ_ADDR = 1'b1;  // address / branch helper

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] raw;
  } alu_ctl_t;

endpackage

// File: rtl/ALU.sv
// ---------------------------------------------------------------------------
// ALU
// Combinational MIPS-style integer ALU.
// Ports:
//   OPCODE, FUNC (6)     operation select (R-type uses FUNC)
//   RS_VAL, RT_VAL (W)   register operands
//   SHAMT (5)            shift amount for SLL/SRL/SRA
//   RAW_VAL (16)         immediate (sign- or zero-extended per opcode)
//   RESULT (W)           operation result (RS-RT for branches)
//   SIG_B (1)            branch taken for BEQ/BNE, 0 otherwise
// ---------------------------------------------------------------------------
module ALU
  import alu_defs_pkg::*;
#(
  parameter int W_DATA = 32
) (
  input  logic [5:0]        OPCODE,
  input  logic [W_DATA-1:0] RS_VAL,
  input  logic [W_DATA-1:0] RT_VAL,
  input  logic [4:0]        SHAMT,
  input  logic [5:0]        FUNC,
  input  logic [15:0]       RAW_VAL,
  output logic [W_DATA-1:0] RESULT,
  output logic              SIG_B
);

  logic signed [W_DATA-1:0] rs_s;
  logic signed [W_DATA-1:0] rt_s;
  logic signed [W_DATA-1:0] imm_s;
  logic        [W_DATA-1:0] imm_z;

  assign rs_s  = RS_VAL;
  assign rt_s  = RT_VAL;
  assign imm_s = {{(W_DATA-16){RAW_VAL[15]}}, RAW_VAL};
  assign imm_z = {{(W_DATA-16){1'b0}}, RAW_VAL};

  function automatic logic [W_DATA-1:0] flag_word(input logic f);
    return {{(W_DATA-1){1'b0}}, f};
  endfunction

  always_comb begin
    RESULT = '0;
    SIG_B  = 1'b0;
    case (OPCODE)
      OP_RTYPE: begin
        case (FUNC)
          FUNC_SLL:              RESULT = RT_VAL << SHAMT;
          FUNC_SRL:              RESULT = RT_VAL >> SHAMT;
          FUNC_SRA:              RESULT = rt_s >>> SHAMT;
          FUNC_ADD, FUNC_ADDU:   RESULT = RS_VAL + RT_VAL;
          FUNC_SUB, FUNC_SUBU:   RESULT = RS_VAL - RT_VAL;
          FUNC_AND:              RESULT = RS_VAL & RT_VAL;
          FUNC_OR:               RESULT = RS_VAL | RT_VAL;
          FUNC_XOR:              RESULT = RS_VAL ^ RT_VAL;
          FUNC_NOR:              RESULT = ~(RS_VAL | RT_VAL);
          FUNC_SLT:              RESULT = flag_word(rs_s < rt_s);
          FUNC_SLTU:             RESULT = flag_word(RS_VAL < RT_VAL);
          default:               RESULT = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: RESULT = rs_s + imm_s;
      OP_SLTI:           RESULT = flag_word(rs_s < imm_s);
      OP_ANDI:           RESULT = RS_VAL & imm_z;
      OP_ORI:            RESULT = RS_VAL | imm_z;
      OP_XORI:           RESULT = RS_VAL ^ imm_z;
      OP_LUI:            RESULT = imm_z << 16;
      OP_BEQ: begin
        RESULT = RS_VAL - RT_VAL;
        SIG_B  = (RS_VAL == RT_VAL);
      end
      OP_BNE: begin
        RESULT = RS_VAL - RT_VAL;
        SIG_B  = (RS_VAL != RT_VAL);
      end
      default: RESULT = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a single priority pointer.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   REQ[1:0]   level requests
//   GNT[1:0]   combinational one-hot grant (forced 0 during RST)
//   GNT_ID     winning port; equals the priority pointer when nobody asks,
//              so it can steer a datapath mux every cycle
// ---------------------------------------------------------------------------
module rr_arb2
  import alu_defs_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  output logic [1:0] GNT,
  output logic       GNT_ID
);

  logic pri;

  always_comb begin
    GNT_ID = pri;
    if (REQ == 2'b01) begin
      GNT_ID = REQ_EXEC;
    end else if (REQ == 2'b10) begin
      GNT_ID = REQ_ADDR;
    end
    GNT = 2'b00;
    if (!RST && (REQ != 2'b00)) begin
      GNT = (GNT_ID == REQ_ADDR) ? 2'b10 : 2'b01;
    end
  end

  // The loser of this grant gets first claim next time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pri <= REQ_EXEC;
    end else if (GNT != 2'b00) begin
      pri <= ~GNT_ID;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between the execute stage (port 0) and the
// address/branch helper (port 1). A round-robin arbiter grants one port per
// cycle; the ALU output is registered and returned one cycle later as a
// single-cycle RSP_VALID pulse tagged with the owning port.
//
// Optional build macro: ALU_ARB_GRANT_CNT_EN adds saturating per-port grant
// counters GRANT_CNT0/GRANT_CNT1 (CNT_W bits).
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   REQx                           level request, held until GNTx
//   OPCODEx/RS_VALx/RT_VALx/SHAMTx/FUNCx/RAW_VALx  operation fields
//   GNTx                           combinational grant, operands consumed now
//   RSP_VALID/RSP_ID               response pulse and owning port
//   RSP_RESULT/RSP_SIG_B           registered ALU RESULT / SIG_B
//   GRANT_CNT0/1                   grant counters (optional)
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import alu_defs_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [5:0]        OPCODE0,
  input  logic [5:0]        OPCODE1,
  input  logic [W_DATA-1:0] RS_VAL0,
  input  logic [W_DATA-1:0] RS_VAL1,
  input  logic [W_DATA-1:0] RT_VAL0,
  input  logic [W_DATA-1:0] RT_VAL1,
  input  logic [4:0]        SHAMT0,
  input  logic [4:0]        SHAMT1,
  input  logic [5:0]        FUNC0,
  input  logic [5:0]        FUNC1,
  input  logic [15:0]       RAW_VAL0,
  input  logic [15:0]       RAW_VAL1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              RSP_VALID,
  output logic              RSP_ID,
  output logic [W_DATA-1:0] RSP_RESULT,
  output logic              RSP_SIG_B
`ifdef ALU_ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  GRANT_CNT0,
  output logic [CNT_W-1:0]  GRANT_CNT1
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]        gnt;
  logic              gnt_id;
  alu_ctl_t          ctl_p0;
  logic [W_DATA-1:0] rs_p0;
  logic [W_DATA-1:0] rt_p0;
  logic [W_DATA-1:0] result_p0;
  logic              sig_b_p0;
  logic              vld_p0;

  logic              vld_p1;
  logic              id_p1;
  logic [W_DATA-1:0] result_p1;
  logic              sig_b_p1;

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    ({REQ1, REQ0}),
    .GNT    (gnt),
    .GNT_ID (gnt_id)
  );

  assign GNT0   = gnt[0];
  assign GNT1   = gnt[1];
  assign vld_p0 = |gnt;

  // ---- Stage p0: operand mux into the shared ALU ----
  always_comb begin
    if (gnt_id == REQ_ADDR) begin
      ctl_p0 = '{opcode: OPCODE1, shamt: SHAMT1, func: FUNC1, raw: RAW_VAL1};
      rs_p0  = RS_VAL1;
      rt_p0  = RT_VAL1;
    end else begin
      ctl_p0 = '{opcode: OPCODE0, shamt: SHAMT0, func: FUNC0, raw: RAW_VAL0};
      rs_p0  = RS_VAL0;
      rt_p0  = RT_VAL0;
    end
  end

  ALU #(.W_DATA(W_DATA)) u_alu (
    .OPCODE  (ctl_p0.opcode),
    .RS_VAL  (rs_p0),
    .RT_VAL  (rt_p0),
    .SHAMT   (ctl_p0.shamt),
    .FUNC    (ctl_p0.func),
    .RAW_VAL (ctl_p0.raw),
    .RESULT  (result_p0),
    .SIG_B   (sig_b_p0)
  );

  // ---- Stage p1: response registers (hold when no grant) ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1    <= 1'b0;
      id_p1     <= REQ_EXEC;
      result_p1 <= '0;
      sig_b_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        id_p1     <= gnt_id;
        result_p1 <= result_p0;
        sig_b_p1  <= sig_b_p0;
      end
    end
  end

  assign RSP_VALID  = vld_p1;
  assign RSP_ID     = id_p1;
  assign RSP_RESULT = result_p1;
  assign RSP_SIG_B  = sig_b_p1;

`ifdef ALU_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt[0]) cnt0_q <= sat_inc(cnt0_q);
      if (gnt[1]) cnt1_q <= sat_inc(cnt1_q);
    end
  end

  assign GRANT_CNT0 = cnt0_q;
  assign GRANT_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Table-driven bench for alu_share_arbiter with a response scoreboard.
// Each row gives the two ports' requests and operations plus the expected
// grant; granted rows push the expected response, which is popped and
// compared when the following cycle's outputs are sampled.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W = 32;
  localparam int CW = 2;

  typedef struct {
    logic [5:0]  opc;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] raw;
    logic [W-1:0] res;
    logic        sigb;
  } op_t;

  typedef struct {
    logic       r0;
    logic       r1;
    op_t        a;
    op_t        b;
    logic [1:0] g;   // {GNT1, GNT0}
  } vec_t;

  typedef struct {
    logic        id;
    logic [W-1:0] res;
    logic        sigb;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [5:0]  opcode0, opcode1, func0, func1;
  logic [W-1:0] rs0, rs1, rt0, rt1;
  logic [4:0]  shamt0, shamt1;
  logic [15:0] raw0, raw1;
  logic gnt0, gnt1, rsp_valid, rsp_id, rsp_sig_b;
  logic [W-1:0] rsp_result;
  logic [CW-1:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  rsp_t sb[$];
  vec_t vt[15];

  always #5 clk = ~clk;

  alu_share_arbiter #(.W_DATA(W), .CNT_W(CW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ0       (req0),
    .REQ1       (req1),
    .OPCODE0    (opcode0),
    .OPCODE1    (opcode1),
    .RS_VAL0    (rs0),
    .RS_VAL1    (rs1),
    .RT_VAL0    (rt0),
    .RT_VAL1    (rt1),
    .SHAMT0     (shamt0),
    .SHAMT1     (shamt1),
    .FUNC0      (func0),
    .FUNC1      (func1),
    .RAW_VAL0   (raw0),
    .RAW_VAL1   (raw1),
    .GNT0       (gnt0),
    .GNT1       (gnt1),
    .RSP_VALID  (rsp_valid),
    .RSP_ID     (rsp_id),
    .RSP_RESULT (rsp_result),
    .RSP_SIG_B  (rsp_sig_b)
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    .GRANT_CNT0 (cnt0),
    .GRANT_CNT1 (cnt1)
`endif
  );

`ifndef ALU_ARB_GRANT_CNT_EN
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

  function automatic op_t mk(input logic [5:0] opc, input logic [W-1:0] rs,
                             input logic [W-1:0] rt, input logic [4:0] sh,
                             input logic [5:0] fn, input logic [15:0] raw,
                             input logic [W-1:0] res, input logic sigb);
    op_t o;
    o.opc = opc; o.rs = rs; o.rt = rt; o.sh = sh;
    o.fn = fn; o.raw = raw; o.res = res; o.sigb = sigb;
    return o;
  endfunction

  function automatic vec_t mkv(input logic r0, input logic r1, input op_t a,
                               input op_t b, input logic [1:0] g);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a = a; v.b = b; v.g = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, advance to just after posedge.
  task automatic step(input logic rst_v, input logic r0, input logic r1,
                      input op_t a, input op_t b, input logic [1:0] g,
                      input string nm);
    rsp_t e;
    rst = rst_v; req0 = r0; req1 = r1;
    opcode0 = a.opc; rs0 = a.rs; rt0 = a.rt; shamt0 = a.sh; func0 = a.fn; raw0 = a.raw;
    opcode1 = b.opc; rs1 = b.rs; rt1 = b.rt; shamt1 = b.sh; func1 = b.fn; raw1 = b.raw;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, "_rsp_id"}, 64'(rsp_id), 64'(e.id));
      chk({nm, "_rsp_result"}, 64'(rsp_result), 64'(e.res));
      chk({nm, "_rsp_sig_b"}, 64'(rsp_sig_b), 64'(e.sigb));
    end else begin
      chk({nm, "_rsp_idle"}, 64'(rsp_valid), 64'd0);
    end
    chk({nm, "_gnt"}, 64'({gnt1, gnt0}), 64'(g));
    if (!rst_v && g != 2'b00) begin
      if (g == 2'b10) begin
        e.id = 1'b1; e.res = b.res; e.sigb = b.sigb;
      end else begin
        e.id = 1'b0; e.res = a.res; e.sigb = a.sigb;
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    op_t nop, srl12, srl22, srl35, add_o, sub_o, ori_o, addi_o, beq_o, bne_o;
    op_t slt_o, sltu_o, sra_o, lui_o;
    logic [CW-1:0] exp_cnt[5];

    nop    = mk(6'b000000, 0, 0, 0, 6'b000000, 0, 0, 0);
    srl12  = mk(6'b000000, 0, 12, 1, 6'b000010, 0, 6, 0);
    srl22  = mk(6'b000000, 0, 22, 1, 6'b000010, 0, 11, 0);
    srl35  = mk(6'b000000, 0, 35, 1, 6'b000010, 0, 17, 0);
    add_o  = mk(6'b000000, 100, 32'hFFFF_FFE2, 0, 6'b100000, 0, 70, 0);
    sub_o  = mk(6'b000000, 5, 9, 0, 6'b100010, 0, 32'hFFFF_FFFC, 0);
    ori_o  = mk(6'b001101, 32'h0000_F000, 0, 0, 0, 16'h00FF, 32'h0000_F0FF, 0);
    addi_o = mk(6'b001000, 10, 0, 0, 0, 16'hFFFF, 9, 0);
    beq_o  = mk(6'b000100, 7, 7, 0, 0, 0, 0, 1);
    bne_o  = mk(6'b000101, 5, 3, 0, 0, 0, 2, 1);
    slt_o  = mk(6'b000000, 32'hFFFF_FFFF, 1, 0, 6'b101010, 0, 1, 0);
    sltu_o = mk(6'b000000, 32'hFFFF_FFFF, 1, 0, 6'b101011, 0, 0, 0);
    sra_o  = mk(6'b000000, 0, 32'h8000_0000, 4, 6'b000011, 0, 32'hF800_0000, 0);
    lui_o  = mk(6'b001111, 0, 0, 0, 0, 16'h1234, 32'h1234_0000, 0);

    vt[0]  = mkv(1, 1, srl22, srl35, 2'b01);
    vt[1]  = mkv(1, 1, srl22, srl35, 2'b10);
    vt[2]  = mkv(1, 1, srl22, srl35, 2'b01);
    vt[3]  = mkv(1, 1, srl22, srl35, 2'b10);
    vt[4]  = mkv(1, 0, srl12, nop,   2'b01);
    vt[5]  = mkv(0, 0, nop,   nop,   2'b00);
    vt[6]  = mkv(0, 0, nop,   nop,   2'b00);
    vt[7]  = mkv(1, 1, add_o, sub_o, 2'b10);
    vt[8]  = mkv(1, 1, ori_o, addi_o, 2'b01);
    vt[9]  = mkv(0, 1, nop,   beq_o, 2'b10);
    vt[10] = mkv(1, 0, bne_o, nop,   2'b01);
    vt[11] = mkv(0, 1, nop,   slt_o, 2'b10);
    vt[12] = mkv(1, 1, sltu_o, sra_o, 2'b01);
    vt[13] = mkv(1, 0, lui_o, nop,   2'b01);
    vt[14] = mkv(1, 1, add_o, sub_o, 2'b00);

    // Reset held 3 cycles with both ports requesting.
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    opcode0 = 0; rs0 = 0; rt0 = 0; shamt0 = 0; func0 = 0; raw0 = 0;
    opcode1 = 0; rs1 = 0; rt1 = 0; shamt1 = 0; func1 = 0; raw1 = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, srl22, srl35, 2'b00, $sformatf("reset%0d", i));
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_sig_b", 64'(rsp_sig_b), 64'd0);

    // Contention, single op and idle gap.
    for (int i = 0; i < 7; i++) step(1'b0, vt[i].r0, vt[i].r1, vt[i].a, vt[i].b, vt[i].g, $sformatf("row%0d", i));
    chk("idle_hold_valid", 64'(rsp_valid), 64'd0);
    chk("idle_hold_result", 64'(rsp_result), 64'd6);
    chk("idle_hold_id", 64'(rsp_id), 64'd0);

    // Mixed operations after the idle gap (row 7 shows PRI survived idles).
    for (int i = 7; i < 14; i++) step(1'b0, vt[i].r0, vt[i].r1, vt[i].a, vt[i].b, vt[i].g, $sformatf("row%0d", i));

    // Reset in a cycle where port 1 holds priority.
    step(1'b1, vt[14].r0, vt[14].r1, vt[14].a, vt[14].b, vt[14].g, "midrst");
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_id", 64'(rsp_id), 64'd0);
    chk("midrst_result", 64'(rsp_result), 64'd0);
    chk("midrst_sig_b", 64'(rsp_sig_b), 64'd0);
    step(1'b0, 1'b1, 1'b1, srl22, srl35, 2'b01, "post_rst");
    step(1'b0, 1'b0, 1'b0, nop, nop, 2'b00, "flush0");

`ifdef ALU_ARB_GRANT_CNT_EN
    step(1'b1, 1'b0, 1'b0, nop, nop, 2'b00, "cnt_rst");
    chk("cnt0_reset", 64'(cnt0), 64'd0);
    chk("cnt1_reset", 64'(cnt1), 64'd0);
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, srl12, nop, 2'b01, $sformatf("cnt_g%0d", i));
      chk($sformatf("cnt0_%0d", i), 64'(cnt0), 64'(exp_cnt[i]));
      chk($sformatf("cnt1_%0d", i), 64'(cnt1), 64'd0);
    end
    step(1'b0, 1'b0, 1'b0, nop, nop, 2'b00, "flush1");
`else
    exp_cnt[0] = '0;
    chk("cnt_absent", 64'(cnt0), 64'(exp_cnt[0]));
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
